// File: rtl/rom_download_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_download_packer_if
//  Description : SDRAM channel-3 write port. The packer drives the request,
//                address, data and byte enables; the controller returns a
//                one-cycle write-complete pulse.
//  Revision    : 1.0  initial release
// ============================================================================
interface rom_download_packer_if;
    logic [24:0] sdr_addr;
    logic [15:0] sdr_data;
    logic [1:0]  sdr_be;
    logic        sdr_req;
    logic        sdr_rdy;

    modport master (
        output sdr_addr,
        output sdr_data,
        output sdr_be,
        output sdr_req,
        input  sdr_rdy
    );

    modport slave (
        input  sdr_addr,
        input  sdr_data,
        input  sdr_be,
        input  sdr_req,
        output sdr_rdy
    );
endinterface
`default_nettype wire

// File: rtl/rom_download_packer.sv
`default_nettype none
// ============================================================================
//  Module      : rom_download_packer
//  Description : Packs the ioctl byte download stream into 16-bit SDRAM
//                writes with byte enables, routes the upper address window
//                to six BRAM chip selects, back-pressures the loader while a
//                write is outstanding and flushes a dangling even byte when
//                the download ends.
//  Revision    : 1.0  initial release
// ============================================================================
module rom_download_packer #(
    parameter logic [24:0] BRAM_BASE     = 25'h0100000,
    parameter int          BRAM_CS_SHIFT = 15,
    parameter int          WORDS_W       = 16
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [24:0]           ioctl_addr,
    input  logic [7:0]            ioctl_data,
    output logic                  ioctl_wait,
    rom_download_packer_if.master sdr,
    output logic [19:0]           bram_addr,
    output logic [7:0]            bram_data,
    output logic [5:0]            bram_cs,
    output logic                  bram_wr,
    output logic [WORDS_W-1:0]    words_written,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR1  = 2'd1,
        WR2  = 2'd2
    } state_t;

    localparam logic [24:0] c_OFF_MASK = (25'd1 << BRAM_CS_SHIFT) - 25'd1;

    state_t             state_q, state_d;
    logic               hold_valid_q, hold_valid_d;
    logic [24:0]        hold_addr_q, hold_addr_d;
    logic [7:0]         hold_data_q, hold_data_d;
    logic               queue_valid_q, queue_valid_d;
    logic [24:0]        queue_addr_q, queue_addr_d;
    logic [7:0]         queue_data_q, queue_data_d;
    logic               req_q, req_d;
    logic [24:0]        addr_q, addr_d;
    logic [15:0]        data_q, data_d;
    logic [1:0]         be_q, be_d;
    logic               bram_wr_q, bram_wr_d;
    logic [5:0]         bram_cs_q, bram_cs_d;
    logic [19:0]        bram_addr_q, bram_addr_d;
    logic [7:0]         bram_data_q, bram_data_d;
    logic [WORDS_W-1:0] words_q, words_d;
    logic               done_q, done_d;
    logic               drain_q, drain_d;
    logic               dl_q;

    logic        w_accept;
    logic        w_rise;
    logic        w_fall;
    logic        w_rdy;
    logic        w_is_sdram;
    logic        w_hold_valid;
    logic        w_drain;
    logic [24:0] w_off;
    logic [24:0] w_idx;
    logic [24:0] w_even_addr;

    assign w_rise       = ioctl_download & ~dl_q;
    assign w_fall       = ~ioctl_download & dl_q;
    assign w_accept     = ioctl_wr & ioctl_download & (state_q == IDLE);
    assign w_rdy        = sdr.sdr_rdy & req_q;
    assign w_is_sdram   = (ioctl_addr < BRAM_BASE);
    assign w_off        = ioctl_addr - BRAM_BASE;
    assign w_idx        = w_off >> BRAM_CS_SHIFT;
    assign w_even_addr  = {ioctl_addr[24:1], 1'b0};
    // A new download window throws away any half-word left from the last one.
    assign w_hold_valid = hold_valid_q & ~w_rise;
    // Drain request is remembered from the falling edge until it is served.
    assign w_drain      = (w_fall | drain_q) & ~w_rise;

    // Next-state, packing, BRAM routing and counter logic.
    always_comb begin
        state_d       = state_q;
        hold_valid_d  = w_hold_valid;
        hold_addr_d   = hold_addr_q;
        hold_data_d   = hold_data_q;
        queue_valid_d = queue_valid_q;
        queue_addr_d  = queue_addr_q;
        queue_data_d  = queue_data_q;
        req_d         = req_q;
        addr_d        = addr_q;
        data_d        = data_q;
        be_d          = be_q;
        bram_wr_d     = 1'b0;
        bram_cs_d     = 6'd0;
        bram_addr_d   = 20'd0;
        bram_data_d   = 8'd0;
        done_d        = 1'b0;
        drain_d       = w_drain;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_sdram) begin
                        if (!ioctl_addr[0]) begin
                            // Even byte: push out any older even byte first.
                            if (w_hold_valid) begin
                                state_d = WR1;
                                req_d   = 1'b1;
                                addr_d  = hold_addr_q;
                                data_d  = {8'h00, hold_data_q};
                                be_d    = 2'b01;
                            end
                            hold_valid_d = 1'b1;
                            hold_addr_d  = ioctl_addr;
                            hold_data_d  = ioctl_data;
                        end else if (w_hold_valid && (hold_addr_q == w_even_addr)) begin
                            state_d      = WR1;
                            req_d        = 1'b1;
                            addr_d       = w_even_addr;
                            data_d       = {ioctl_data, hold_data_q};
                            be_d         = 2'b11;
                            hold_valid_d = 1'b0;
                        end else if (w_hold_valid) begin
                            // Unrelated odd byte: flush hold, then the odd byte.
                            state_d       = WR1;
                            req_d         = 1'b1;
                            addr_d        = hold_addr_q;
                            data_d        = {8'h00, hold_data_q};
                            be_d          = 2'b01;
                            hold_valid_d  = 1'b0;
                            queue_valid_d = 1'b1;
                            queue_addr_d  = w_even_addr;
                            queue_data_d  = ioctl_data;
                        end else begin
                            state_d = WR1;
                            req_d   = 1'b1;
                            addr_d  = w_even_addr;
                            data_d  = {ioctl_data, 8'h00};
                            be_d    = 2'b10;
                        end
                    end else if (w_idx < 25'd6) begin
                        bram_wr_d   = 1'b1;
                        bram_cs_d   = 6'b000001 << w_idx[2:0];
                        bram_addr_d = w_off[19:0] & c_OFF_MASK[19:0];
                        bram_data_d = ioctl_data;
                    end
                end else if (w_drain) begin
                    if (w_hold_valid) begin
                        state_d      = WR1;
                        req_d        = 1'b1;
                        addr_d       = hold_addr_q;
                        data_d       = {8'h00, hold_data_q};
                        be_d         = 2'b01;
                        hold_valid_d = 1'b0;
                    end else begin
                        done_d  = 1'b1;
                        drain_d = 1'b0;
                    end
                end
            end
            WR1: begin
                if (w_rdy) begin
                    req_d   = 1'b0;
                    state_d = queue_valid_q ? WR2 : IDLE;
                end
            end
            WR2: begin
                // Request stays low for one cycle between WR1 and WR2.
                if (!req_q) begin
                    req_d         = 1'b1;
                    addr_d        = queue_addr_q;
                    data_d        = {queue_data_q, 8'h00};
                    be_d          = 2'b10;
                    queue_valid_d = 1'b0;
                end else if (w_rdy) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (w_rise) begin
            words_d = '0;
        end else if (w_rdy && (state_q != IDLE) && (words_q != '1)) begin
            words_d = words_q + 1'b1;
        end else begin
            words_d = words_q;
        end
    end

    // State and output registers, cleared asynchronously by RSTn.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= IDLE;
            hold_valid_q  <= 1'b0;
            hold_addr_q   <= 25'd0;
            hold_data_q   <= 8'd0;
            queue_valid_q <= 1'b0;
            queue_addr_q  <= 25'd0;
            queue_data_q  <= 8'd0;
            req_q         <= 1'b0;
            addr_q        <= 25'd0;
            data_q        <= 16'd0;
            be_q          <= 2'b00;
            bram_wr_q     <= 1'b0;
            bram_cs_q     <= 6'd0;
            bram_addr_q   <= 20'd0;
            bram_data_q   <= 8'd0;
            words_q       <= '0;
            done_q        <= 1'b0;
            drain_q       <= 1'b0;
            dl_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_valid_q  <= hold_valid_d;
            hold_addr_q   <= hold_addr_d;
            hold_data_q   <= hold_data_d;
            queue_valid_q <= queue_valid_d;
            queue_addr_q  <= queue_addr_d;
            queue_data_q  <= queue_data_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            be_q          <= be_d;
            bram_wr_q     <= bram_wr_d;
            bram_cs_q     <= bram_cs_d;
            bram_addr_q   <= bram_addr_d;
            bram_data_q   <= bram_data_d;
            words_q       <= words_d;
            done_q        <= done_d;
            drain_q       <= drain_d;
            dl_q          <= ioctl_download;
        end
    end

    assign ioctl_wait    = (state_q != IDLE);
    assign sdr.sdr_req   = req_q;
    assign sdr.sdr_addr  = addr_q;
    assign sdr.sdr_data  = data_q;
    assign sdr.sdr_be    = be_q;
    assign bram_wr       = bram_wr_q;
    assign bram_cs       = bram_cs_q;
    assign bram_addr     = bram_addr_q;
    assign bram_data     = bram_data_q;
    assign words_written = words_q;
    assign done          = done_q;

endmodule
`default_nettype wire
